adsb_config_controller: RTL and testbench
=========================================

Name: adsb_config_controller

Overview:
- Receives 64-bit ADS-B config frames over a 32-bit AXI-stream slave (two beats, low word first), validates them and drives the static control registers of the demodulator datapath.
- Sequences a timed soft-reset pulse for the demodulator and reporter, and counts malformed frames.
- Sits between the PS config DMA stream and the demodulator's control inputs. Clock-domain crossing of its outputs is not in this block.

Parameters:
- AXI_DATA_WIDTH, 32, stream data width; only 32 is supported.
- MODULE_ID, 8'h01, module-id byte that frames must carry.
- RST_HOLD_CYCLES, 16, cycles the Demod_rst output is held high per reset request (>=1).
- ERR_COUNT_WIDTH, 16, width of the error counter (saturating).

Ports:
- S_axis_clk  in  1  sole clock.
- S_axis_resetn  in  1  reset, asynchronous assert, active-low.
- S_axis_valid  in  1  config beat valid.
- S_axis_ready  out  1  config beat accepted when valid&&ready.
- S_axis_data  in  AXI_DATA_WIDTH  config beat.
- S_axis_last  in  1  last beat of frame.
- Demod_enable  out  1  demodulator enable.
- Demod_rst  out  1  soft-reset pulse, RST_HOLD_CYCLES long.
- Report_all  out  1  also report CRC-fail messages.
- Preamble_shift  out  8  preamble S/N threshold shift.
- Preamble_threshold  out  32  absolute preamble power threshold.
- Frame_error_count  out  ERR_COUNT_WIDTH  count of rejected frames.

Behaviour:
- Reset (S_axis_resetn=0, async): S_axis_ready=0, Demod_enable=0, Demod_rst=1, Report_all=0, Preamble_shift=0, Preamble_threshold=0, Frame_error_count=0, state=S_RESET_HOLD with hold counter=RST_HOLD_CYCLES-1.
- Frame format:
  - Word0: [31:16] magic 16'hAD5B, [15:8] module_id, [7:0] msg_type.
  - Word1 payload, for msg_type 8'h01 (control): [0] enable, [8] reset request, [16] report_all, [31:24] preamble_shift.
  - Word1 payload, for msg_type 8'h02 (threshold): [31:0] preamble_threshold.
- State machine:
  - S_WORD0: ready=1. On a beat, latch word0.
    - last=1 -> error, stay in S_WORD0.
    - Otherwise -> S_WORD1.
  - S_WORD1: ready=1. On a beat, latch word1.
    - last=1 -> S_APPLY.
    - last=0 -> error, S_DRAIN.
  - S_DRAIN: ready=1. Discard beats until a beat with last=1, then -> S_WORD0.
  - S_APPLY: ready=0, one cycle.
    - If magic or module_id mismatch, or msg_type not in {01,02}: error, no register change.
    - Else apply payload; registers update on exit from S_APPLY.
    - Control frame with reset=1: load hold counter=RST_HOLD_CYCLES-1, Demod_rst=1 next cycle, -> S_RESET_HOLD.
    - Otherwise -> S_WORD0.
  - S_RESET_HOLD: ready=0, Demod_rst=1. Decrement counter; at 0 drive Demod_rst=0 -> S_WORD0.
- Register latency: a config register changes 2 cycles after the word1 handshake (one cycle to S_APPLY, then update).
- Control frame sequencing: Demod_enable, Report_all and Preamble_shift update together with the Demod_rst assertion, so the enable edge never precedes the reset.
- Error counting: each "error" increments Frame_error_count by 1. The counter saturates at all-ones and never wraps. At most one increment per frame.
- Ready and backpressure:
  - Ready is registered-state driven: it depends only on state and never combinationally on S_axis_valid.
  - While ready=0, upstream must hold the beat.
- Unused payload bits are ignored.
- Reset mid-frame: partial frame discarded; the bench must resend from word0.

Decomposition:
- Add to adsb_pkg:
  - adsb_config_magic (16'hAD5B)
  - msg_type constants ADSB_CFG_MSG_CONTROL=8'h01, ADSB_CFG_MSG_THRESHOLD=8'h02
  - packed struct adsb_config_header_t {magic, module_id, msg_type}
  - packed struct adsb_config_control_t for word1
- No sub-module: single FSM plus registers. The saturating counter stays inline.

Test Plan:
- Post-reset idle: release S_axis_resetn -> Demod_rst high exactly 16 cycles, then ready=1, all config outputs 0.
- Frame {AD5B0101, 00000001} -> Demod_enable=1 two cycles after last beat, Demod_rst stays 0, error count 0.
- Frame {AD5B0101, 05010101} -> Demod_rst=1 for 16 cycles with ready=0; Demod_enable=1, Report_all=1, Preamble_shift=5 on the same cycle Demod_rst rises.
- Frame {AD5B0102, 0000_1234} -> Preamble_threshold=32'h1234, other outputs unchanged.
- Bad frames, each followed by a good control frame that must still apply:
  - {DEAD0101, 1}
  - {AD5B0201, 1}
  - 1-beat frame
  - 3-beat frame
  - -> Frame_error_count=4, no register change from the bad frames.
- Random valid gaps and S_axis_resetn pulse between word0 and word1 -> frame dropped, outputs return to reset values, next complete frame applies normally.

Source files
------------

// File: rtl/adsb_config_controller_pkg.sv
// Shared definitions for the ADS-B config stream: frame magic, message types,
// word layouts and controller state encoding.
package adsb_pkg;

  localparam logic [15:0] adsb_config_magic      = 16'hAD5B;
  localparam logic [7:0]  ADSB_CFG_MSG_CONTROL   = 8'h01;
  localparam logic [7:0]  ADSB_CFG_MSG_THRESHOLD = 8'h02;

  typedef struct packed {
    logic [15:0] magic;
    logic [7:0]  module_id;
    logic [7:0]  msg_type;
  } adsb_config_header_t;

  typedef struct packed {
    logic [7:0] preamble_shift;
    logic [6:0] rsvd_23_17;
    logic       report_all;
    logic [6:0] rsvd_15_9;
    logic       reset_req;
    logic [6:0] rsvd_7_1;
    logic       enable;
  } adsb_config_control_t;

  typedef enum logic [2:0] {
    S_RESET_HOLD,
    S_WORD0,
    S_WORD1,
    S_DRAIN,
    S_APPLY
  } adsb_cfg_state_e;

  function automatic logic adsb_header_ok(input adsb_config_header_t hdr,
                                          input logic [7:0]          module_id);
    return (hdr.magic == adsb_config_magic) && (hdr.module_id == module_id) &&
           ((hdr.msg_type == ADSB_CFG_MSG_CONTROL) ||
            (hdr.msg_type == ADSB_CFG_MSG_THRESHOLD));
  endfunction

endpackage

// File: rtl/adsb_config_controller.sv
// Two-beat AXI-stream config frame receiver driving the demodulator's static
// control registers, timed soft-reset pulse and saturating frame-error counter.
module adsb_config_controller
  import adsb_pkg::*;
#(
  parameter int unsigned AXI_DATA_WIDTH  = 32,
  parameter logic [7:0]  MODULE_ID       = 8'h01,
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned ERR_COUNT_WIDTH = 16
) (
  input  logic                       S_axis_clk,
  input  logic                       S_axis_resetn,
  input  logic                       S_axis_valid,
  output logic                       S_axis_ready,
  input  logic [AXI_DATA_WIDTH-1:0]  S_axis_data,
  input  logic                       S_axis_last,
  output logic                       Demod_enable,
  output logic                       Demod_rst,
  output logic                       Report_all,
  output logic [7:0]                 Preamble_shift,
  output logic [31:0]                Preamble_threshold,
  output logic [ERR_COUNT_WIDTH-1:0] Frame_error_count
);

  localparam int unsigned CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_HOLD_CYCLES - 1);

  adsb_cfg_state_e             state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  adsb_config_header_t         hdr_q, hdr_d;
  adsb_config_control_t        pay_q, pay_d;
  logic                        rst_q, rst_d;
  logic                        enable_q, enable_d;
  logic                        report_q, report_d;
  logic [7:0]                  shift_q, shift_d;
  logic [31:0]                 thresh_q, thresh_d;
  logic [ERR_COUNT_WIDTH-1:0]  err_q, err_d;
  logic                        err_inc;
  logic                        ready;
  logic                        beat;

  // Ready is a pure function of the registered state, never of valid.
  assign ready = (state_q == S_WORD0) || (state_q == S_WORD1) || (state_q == S_DRAIN);
  assign beat  = S_axis_valid && ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hdr_d    = hdr_q;
    pay_d    = pay_q;
    rst_d    = rst_q;
    enable_d = enable_q;
    report_d = report_q;
    shift_d  = shift_q;
    thresh_d = thresh_q;
    err_inc  = 1'b0;

    unique case (state_q)
      S_WORD0: begin
        if (beat) begin
          hdr_d = S_axis_data[31:0];
          if (S_axis_last) err_inc = 1'b1;
          else             state_d = S_WORD1;
        end
      end
      S_WORD1: begin
        if (beat) begin
          pay_d = S_axis_data[31:0];
          if (S_axis_last) begin
            state_d = S_APPLY;
          end else begin
            err_inc = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (beat && S_axis_last) state_d = S_WORD0;
      end
      S_APPLY: begin
        state_d = S_WORD0;
        if (!adsb_header_ok(hdr_q, MODULE_ID)) begin
          err_inc = 1'b1;
        end else if (hdr_q.msg_type == ADSB_CFG_MSG_CONTROL) begin
          // Enable lands on the same edge as the reset rise, never before it.
          enable_d = pay_q.enable;
          report_d = pay_q.report_all;
          shift_d  = pay_q.preamble_shift;
          if (pay_q.reset_req) begin
            rst_d   = 1'b1;
            cnt_d   = CNT_INIT;
            state_d = S_RESET_HOLD;
          end
        end else begin
          thresh_d = pay_q;
        end
      end
      S_RESET_HOLD: begin
        if (cnt_q == '0) begin
          rst_d   = 1'b0;
          state_d = S_WORD0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_WORD0;
    endcase

    err_d = (err_inc && (err_q != '1)) ? err_q + ERR_COUNT_WIDTH'(1) : err_q;
  end

  always_ff @(posedge S_axis_clk or negedge S_axis_resetn) begin
    if (!S_axis_resetn) begin
      state_q  <= S_RESET_HOLD;
      cnt_q    <= CNT_INIT;
      hdr_q    <= '0;
      pay_q    <= '0;
      rst_q    <= 1'b1;
      enable_q <= 1'b0;
      report_q <= 1'b0;
      shift_q  <= '0;
      thresh_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hdr_q    <= hdr_d;
      pay_q    <= pay_d;
      rst_q    <= rst_d;
      enable_q <= enable_d;
      report_q <= report_d;
      shift_q  <= shift_d;
      thresh_q <= thresh_d;
      err_q    <= err_d;
    end
  end

  assign S_axis_ready       = ready;
  assign Demod_rst          = rst_q;
  assign Demod_enable       = enable_q;
  assign Report_all         = report_q;
  assign Preamble_shift     = shift_q;
  assign Preamble_threshold = thresh_q;
  assign Frame_error_count  = err_q;

endmodule

// File: tb/tb_adsb_config_controller.sv
// Self-checking bench for adsb_config_controller against a frame-level model.
module tb_adsb_config_controller;

  localparam int unsigned EW      = 4;
  localparam int unsigned HOLD    = 16;
  localparam int unsigned ERR_MAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          valid = 1'b0;
  logic          last = 1'b0;
  logic [31:0]   data = '0;
  logic          ready;
  logic          d_en, d_rst, d_rep;
  logic [7:0]    d_shift;
  logic [31:0]   d_thr;
  logic [EW-1:0] d_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Frame-level model of the configuration registers
  logic        m_en, m_rep;
  logic [7:0]  m_sh;
  logic [31:0] m_thr;
  int unsigned m_err;

  adsb_config_controller #(
    .AXI_DATA_WIDTH (32),
    .MODULE_ID      (8'h01),
    .RST_HOLD_CYCLES(HOLD),
    .ERR_COUNT_WIDTH(EW)
  ) dut (
    .S_axis_clk        (clk),
    .S_axis_resetn     (resetn),
    .S_axis_valid      (valid),
    .S_axis_ready      (ready),
    .S_axis_data       (data),
    .S_axis_last       (last),
    .Demod_enable      (d_en),
    .Demod_rst         (d_rst),
    .Report_all        (d_rep),
    .Preamble_shift    (d_shift),
    .Preamble_threshold(d_thr),
    .Frame_error_count (d_err)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_en = 1'b0; m_rep = 1'b0; m_sh = '0; m_thr = '0; m_err = 0;
  endfunction

  function automatic void model_error();
    if (m_err < ERR_MAX) m_err++;
  endfunction

  // Returns 1 when the frame should trigger a soft-reset pulse.
  function automatic logic model_frame(input logic [31:0] w[$]);
    logic [31:0] h, p;
    if (w.size() != 2) begin
      model_error();
      return 1'b0;
    end
    h = w[0];
    p = w[1];
    if (h[31:16] != 16'hAD5B || h[15:8] != 8'h01 || (h[7:0] != 8'h01 && h[7:0] != 8'h02)) begin
      model_error();
      return 1'b0;
    end
    if (h[7:0] == 8'h01) begin
      m_en  = p[0];
      m_rep = p[16];
      m_sh  = p[31:24];
      return p[8];
    end
    m_thr = p;
    return 1'b0;
  endfunction

  function automatic logic [47:0] obs_vec();
    return {ready, d_rst, d_en, d_rep, d_shift, d_thr, d_err};
  endfunction

  function automatic logic [47:0] exp_vec(input logic rdy, input logic rst);
    return {rdy, rst, m_en, m_rep, m_sh, m_thr, EW'(m_err)};
  endfunction

  // Drives one beat with a random idle gap; returns at posedge+1 after the handshake.
  task automatic send_beat(input logic [31:0] d, input logic l);
    bit got = 0;
    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    valid = 1'b1; data = d; last = l;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ready) begin got = 1; break; end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL handshake: ready=%b required=1 within 64 cycles", ready);
    end
    @(posedge clk); #1;
    valid = 1'b0; last = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w[$]);
    for (int i = 0; i < w.size(); i++) send_beat(w[i], i == w.size() - 1);
  endtask

  // Counts consecutive high Demod_rst samples, starting from the current one.
  task automatic count_rst(output int n);
    n = 0;
    while (d_rst && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic settle(output int n);
    @(posedge clk); #1;
    count_rst(n);
  endtask

  task automatic test_reset();
    int n;
    logic [47:0] o, e;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    o = obs_vec(); e = exp_vec(1'b0, 1'b1);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_state: got %h required %h", o, e); end
    @(posedge clk); #1;
    resetn = 1'b1;
    count_rst(n);
    n_tests++;
    if (n != HOLD) begin n_fail++; $display("FAIL reset_hold_len: got %0d required %0d", n, HOLD); end
    o = obs_vec(); e = exp_vec(1'b1, 1'b0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL post_reset_idle: got %h required %h", o, e); end
  endtask

  task automatic test_enable();
    logic [31:0] w[$];
    logic [47:0] o, e;
    logic rr;
    w = '{32'hAD5B0101, 32'h00000001};
    send_frame(w);
    o = obs_vec(); e = exp_vec(1'b0, 1'b0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL enable_apply_cycle: got %h required %h", o, e); end
    rr = model_frame(w);
    @(posedge clk); #1;
    o = obs_vec(); e = exp_vec(1'b1, rr);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL enable_updated: got %h required %h", o, e); end
  endtask

  task automatic test_reset_request();
    logic [31:0] w[$];
    logic [47:0] o, e;
    logic rr;
    int n, bad_ready;
    w = '{32'hAD5B0101, 32'h05010101};
    send_frame(w);
    o = obs_vec(); e = exp_vec(1'b0, 1'b0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rstreq_apply_cycle: got %h required %h", o, e); end
    rr = model_frame(w);
    @(posedge clk); #1;
    o = obs_vec(); e = exp_vec(1'b0, rr);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rstreq_rise_together: got %h required %h", o, e); end
    n = 0; bad_ready = 0;
    while (d_rst && n < 100) begin
      if (ready) bad_ready++;
      n++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (n != HOLD) begin n_fail++; $display("FAIL rstreq_hold_len: got %0d required %0d", n, HOLD); end
    n_tests++;
    if (bad_ready != 0) begin n_fail++; $display("FAIL rstreq_ready_low: got %0d ready cycles required 0", bad_ready); end
    o = obs_vec(); e = exp_vec(1'b1, 1'b0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL rstreq_idle: got %h required %h", o, e); end
  endtask

  task automatic test_threshold();
    logic [31:0] w[$];
    logic [47:0] o, e;
    logic rr;
    w = '{32'hAD5B0102, 32'h00001234};
    send_frame(w);
    o = obs_vec(); e = exp_vec(1'b0, 1'b0);
    n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL thresh_apply_cycle: got %h required %h", o, e); end
    rr = model_frame(w);
    @(posedge clk); #1;
    o = obs_vec(); e = exp_vec(1'b1, rr);
    n_tests++;
    if (o !== e || d_thr !== 32'h00001234) begin
      n_fail++; $display("FAIL thresh_updated: got %h required %h", o, e);
    end
  endtask

  task automatic test_bad_frames();
    logic [31:0] w[$];
    logic [31:0] good[$];
    logic [47:0] o, e;
    logic rr;
    int n;
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: w = '{32'hDEAD0101, 32'h00000001};
        1: w = '{32'hAD5B0201, 32'h00000001};
        2: w = '{32'hAD5B0101};
        default: w = '{32'hAD5B0101, 32'h00000000, 32'h00000001};
      endcase
      send_frame(w);
      rr = model_frame(w);
      settle(n);
      o = obs_vec(); e = exp_vec(1'b1, 1'b0);
      n_tests++;
      if (o !== e || n != 0) begin
        n_fail++; $display("FAIL bad_frame_%0d: got %h rst=%0d required %h rst=0", k, o, n, e);
      end
      good = '{32'hAD5B0101, {8'(k + 1), 7'd0, k[0], 15'd0, ~k[0]}};
      send_frame(good);
      rr = model_frame(good);
      settle(n);
      o = obs_vec(); e = exp_vec(1'b1, 1'b0);
      n_tests++;
      if (o !== e || n != 0) begin
        n_fail++; $display("FAIL good_after_bad_%0d: got %h rst=%0d required %h rst=0", k, o, n, e);
      end
    end
    n_tests++;
    if (d_err !== EW'(4)) begin n_fail++; $display("FAIL bad_frame_count: got %0d required 4", d_err); end
  endtask

  task automatic test_midframe_reset();
    logic [31:0] w[$];
    logic [47:0] o, e;
    logic rr;
    int n;
    for (int k = 0; k < 3; k++) begin
      send_beat(32'hAD5B0101, 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      @(negedge clk);
      resetn = 1'b0;
      model_reset();
      #1;
      o = obs_vec(); e = exp_vec(1'b0, 1'b1);
      n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL midframe_async_reset_%0d: got %h required %h", k, o, e); end
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      count_rst(n);
      n_tests++;
      if (n != HOLD) begin n_fail++; $display("FAIL midframe_hold_%0d: got %0d required %0d", k, n, HOLD); end
      w = '{32'hAD5B0101, $urandom() & 32'hFF010001};
      send_frame(w);
      rr = model_frame(w);
      settle(n);
      o = obs_vec(); e = exp_vec(1'b1, 1'b0);
      n_tests++;
      if (o !== e || n != 0) begin
        n_fail++; $display("FAIL midframe_resend_%0d: got %h rst=%0d required %h rst=0", k, o, n, e);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] w[$];
    logic [47:0] o, e;
    logic rr;
    int n, kind;
    for (int k = 0; k < 40; k++) begin
      kind = $urandom_range(0, 6);
      case (kind)
        0: w = '{32'hAD5B0101, $urandom()};
        1: w = '{32'hAD5B0102, $urandom()};
        2: w = '{{16'hAD5B ^ 16'($urandom_range(1, 16'hFFFF)), 16'h0101}, $urandom()};
        3: w = '{{16'hAD5B, 8'($urandom_range(2, 255)), 8'h01}, $urandom()};
        4: w = '{{24'hAD5B01, 8'($urandom_range(3, 255))}, $urandom()};
        5: w = '{32'hAD5B0101};
        default: begin
          w = '{32'hAD5B0101, $urandom(), $urandom()};
          if ($urandom_range(0, 1) == 1) w.push_back($urandom());
        end
      endcase
      send_frame(w);
      rr = model_frame(w);
      settle(n);
      o = obs_vec(); e = exp_vec(1'b1, 1'b0);
      n_tests++;
      if (o !== e || n != (rr ? HOLD : 0)) begin
        n_fail++;
        $display("FAIL random_%0d_kind%0d: got %h rst_len=%0d required %h rst_len=%0d",
                 k, kind, o, n, e, rr ? HOLD : 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_enable();
    test_reset_request();
    test_threshold();
    test_bad_frames();
    test_midframe_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
